// File: rtl/trip_pkg.sv
// Shared encodings and small helpers for the taxi-meter trip sequencer.
package trip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam logic [1:0] DISP_FARE  = 2'd0;
  localparam logic [1:0] DISP_DIST  = 2'd1;
  localparam logic [1:0] DISP_WAIT  = 2'd2;
  localparam logic [1:0] DISP_BLANK = 2'd3;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A limit of 0 fires on the first second tick rather than immediately.
  function automatic logic reached(input logic [7:0] cnt, input logic [7:0] lim,
                                   input logic tick);
    return (lim == 8'd0) ? tick : (cnt >= lim);
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second strobe generator: counts 0..Freq-1 while enabled, cleared on demand.
module sec_tick_gen #(
  parameter logic [25:0] Freq = 26'd50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [25:0] sec_cnt;

  assign tick = en && (sec_cnt == Freq - 26'd1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || clr) sec_cnt <= '0;
    else if (tick)         sec_cnt <= '0;
    else if (en)           sec_cnt <= sec_cnt + 26'd1;
  end

endmodule

// File: rtl/trip_ctrl.sv
// Trip sequencer: key strobes and distance pulses in, meter control and display page out.
module trip_ctrl
  import trip_pkg::*;
#(
  parameter logic [25:0] Freq          = 26'd50_000_000,
  parameter logic [7:0]  AUTO_WAIT_SEC = 8'd5,
  parameter logic [7:0]  SETTLE_SEC    = 8'd10,
  parameter logic [7:0]  ROTATE_SEC    = 8'd3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_start,
  input  logic       key_wait,
  input  logic       key_stop,
  input  logic       pulse_flag,
  output logic       meter_clr,
  output logic       dist_en,
  output logic       wait_en,
  output logic       fare_freeze,
  output logic [1:0] disp_sel,
  output logic       vacant_led,
  output logic       stat_led
);

  state_t     state, state_nxt;
  logic       auto_flag, auto_nxt;
  logic [7:0] idle_cnt, idle_nxt, settle_cnt, settle_nxt, rot_cnt, rot_nxt;
  logic       page, page_nxt;
  logic [1:0] disp_nxt;
  logic       sec_tick, state_chg, idle_to, settle_to, running;

  assign state_chg = (state_nxt != state);
  assign running   = (state == ST_DRIVE) || (state == ST_WAIT);
  assign idle_to   = reached(idle_cnt, AUTO_WAIT_SEC, sec_tick);
  assign settle_to = reached(settle_cnt, SETTLE_SEC, sec_tick);

  sec_tick_gen #(.Freq(Freq)) u_sec_tick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (state_chg),
    .en        (state != ST_IDLE),
    .tick      (sec_tick)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    auto_nxt  = auto_flag;
    case (state)
      ST_IDLE:   if (key_start) state_nxt = ST_DRIVE;
      ST_DRIVE: begin
        if (key_stop) state_nxt = ST_SETTLE;
        else if (key_wait) begin
          state_nxt = ST_WAIT;
          auto_nxt  = 1'b0;
        end else if (!pulse_flag && idle_to) begin
          state_nxt = ST_WAIT;
          auto_nxt  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (key_stop)                     state_nxt = ST_SETTLE;
        else if (key_wait)                state_nxt = ST_DRIVE;
        else if (pulse_flag && auto_flag) state_nxt = ST_DRIVE;
      end
      ST_SETTLE: begin
        if (key_start)      state_nxt = ST_DRIVE;
        else if (settle_to) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    idle_nxt   = (state != ST_DRIVE || state_chg || pulse_flag) ? 8'd0 :
                 (sec_tick ? sat_inc(idle_cnt) : idle_cnt);
    settle_nxt = (state != ST_SETTLE || state_chg) ? 8'd0 :
                 (sec_tick ? sat_inc(settle_cnt) : settle_cnt);
    rot_nxt    = rot_cnt;
    page_nxt   = page;
    if (state_chg || !running) begin
      rot_nxt  = 8'd0;
      page_nxt = 1'b0;
    end else if (sec_tick) begin
      if (reached(sat_inc(rot_cnt), ROTATE_SEC, sec_tick)) begin
        rot_nxt  = 8'd0;
        page_nxt = ~page;
      end else begin
        rot_nxt  = sat_inc(rot_cnt);
      end
    end
    case (state_nxt)
      ST_DRIVE: disp_nxt = page_nxt ? DISP_DIST : DISP_FARE;
      ST_WAIT:  disp_nxt = page_nxt ? DISP_WAIT : DISP_FARE;
      ST_SETTLE: disp_nxt = DISP_FARE;
      default:  disp_nxt = DISP_BLANK;
    endcase
  end

  // Outputs are registered from the next state so they line up with the new state.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      auto_flag   <= 1'b0;
      idle_cnt    <= 8'd0;
      settle_cnt  <= 8'd0;
      rot_cnt     <= 8'd0;
      page        <= 1'b0;
      meter_clr   <= 1'b0;
      dist_en     <= 1'b0;
      wait_en     <= 1'b0;
      fare_freeze <= 1'b1;
      disp_sel    <= DISP_BLANK;
      vacant_led  <= 1'b1;
      stat_led    <= 1'b0;
    end else begin
      state       <= state_nxt;
      auto_flag   <= auto_nxt;
      idle_cnt    <= idle_nxt;
      settle_cnt  <= settle_nxt;
      rot_cnt     <= rot_nxt;
      page        <= page_nxt;
      meter_clr   <= (state_nxt == ST_DRIVE) &&
                     ((state == ST_IDLE) || (state == ST_SETTLE));
      dist_en     <= (state_nxt == ST_DRIVE) || (state_nxt == ST_WAIT);
      wait_en     <= (state_nxt == ST_WAIT);
      fare_freeze <= (state_nxt == ST_IDLE) || (state_nxt == ST_SETTLE);
      disp_sel    <= disp_nxt;
      vacant_led  <= (state_nxt == ST_IDLE);
      stat_led    <= (state_nxt == ST_WAIT);
    end
  end

endmodule

// File: tb/tb_trip_ctrl.sv
// Directed bench for trip_ctrl with a 10-cycle second so timeouts are short.
module tb_trip_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key_start = 1'b0, key_wait = 1'b0, key_stop = 1'b0, pulse_flag = 1'b0;
  logic       meter_clr, dist_en, wait_en, fare_freeze, vacant_led, stat_led;
  logic [1:0] disp_sel;
  logic [7:0] outs;
  int         checks = 0;
  int         failures = 0;

  // Packed view: {meter_clr, dist_en, wait_en, fare_freeze, disp_sel, vacant_led, stat_led}
  localparam logic [7:0] O_IDLE      = 8'b0001_1110;
  localparam logic [7:0] O_DRIVE_CLR = 8'b1100_0000;
  localparam logic [7:0] O_DRIVE     = 8'b0100_0000;
  localparam logic [7:0] O_DRIVE_P1  = 8'b0100_0100;
  localparam logic [7:0] O_WAIT      = 8'b0110_0001;
  localparam logic [7:0] O_SETTLE    = 8'b0001_0000;

  assign outs = {meter_clr, dist_en, wait_en, fare_freeze, disp_sel, vacant_led, stat_led};

  trip_ctrl #(
    .Freq(26'd10), .AUTO_WAIT_SEC(8'd2), .SETTLE_SEC(8'd3), .ROTATE_SEC(8'd2)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_start   (key_start),
    .key_wait    (key_wait),
    .key_stop    (key_stop),
    .pulse_flag  (pulse_flag),
    .meter_clr   (meter_clr),
    .dist_en     (dist_en),
    .wait_en     (wait_en),
    .fare_freeze (fare_freeze),
    .disp_sel    (disp_sel),
    .vacant_led  (vacant_led),
    .stat_led    (stat_led)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic w, input logic st, input logic p);
    key_start = s; key_wait = w; key_stop = st; pulse_flag = p;
    step();
    key_start = 1'b0; key_wait = 1'b0; key_stop = 1'b0; pulse_flag = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if (outs !== O_IDLE) begin
      $display("FAIL reset_held: got %b want %b", outs, O_IDLE); failures++;
    end
    sys_rst_n = 1'b1;
    step();
    checks++;
    if (outs !== O_IDLE) begin
      $display("FAIL reset_release: got %b want %b", outs, O_IDLE); failures++;
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (outs !== O_IDLE) begin
      $display("FAIL idle_ignore_wait: got %b want %b", outs, O_IDLE); failures++;
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (outs !== O_IDLE) begin
      $display("FAIL idle_ignore_stop: got %b want %b", outs, O_IDLE); failures++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (outs !== O_IDLE) begin
      $display("FAIL idle_ignore_pulse: got %b want %b", outs, O_IDLE); failures++;
    end
  endtask

  task automatic test_start();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_DRIVE_CLR) begin
      $display("FAIL start_clr: got %b want %b", outs, O_DRIVE_CLR); failures++;
    end
    step();
    checks++;
    if (outs !== O_DRIVE) begin
      $display("FAIL start_clr_drop: got %b want %b", outs, O_DRIVE); failures++;
    end
  endtask

  // Enters at DRIVE cycle 1; ticks land on cycles 9 and 19, so WAIT shows at cycle 21.
  task automatic test_auto_wait();
    repeat (19) step();
    checks++;
    if (outs !== O_DRIVE_P1) begin
      $display("FAIL pre_auto_wait: got %b want %b", outs, O_DRIVE_P1); failures++;
    end
    step();
    checks++;
    if (outs !== O_WAIT) begin
      $display("FAIL auto_wait: got %b want %b", outs, O_WAIT); failures++;
    end
    repeat (4) step();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (outs !== O_DRIVE) begin
      $display("FAIL auto_resume: got %b want %b", outs, O_DRIVE); failures++;
    end
  endtask

  task automatic test_manual_wait();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (outs !== O_WAIT) begin
      $display("FAIL manual_wait: got %b want %b", outs, O_WAIT); failures++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (outs !== O_WAIT) begin
      $display("FAIL manual_wait_pulse: got %b want %b", outs, O_WAIT); failures++;
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (outs !== O_DRIVE) begin
      $display("FAIL manual_resume: got %b want %b", outs, O_DRIVE); failures++;
    end
  endtask

  task automatic test_stop_settle();
    key_stop = 1'b1; pulse_flag = 1'b1;
    checks++;
    if (outs !== O_DRIVE) begin
      $display("FAIL stop_cycle_dist: got %b want %b", outs, O_DRIVE); failures++;
    end
    step();
    key_stop = 1'b0; pulse_flag = 1'b0;
    checks++;
    if (outs !== O_SETTLE) begin
      $display("FAIL settle_entry: got %b want %b", outs, O_SETTLE); failures++;
    end
    repeat (5) step();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (outs !== O_SETTLE) begin
      $display("FAIL settle_ignore_keys: got %b want %b", outs, O_SETTLE); failures++;
    end
    repeat (23) step();
    checks++;
    if (outs !== O_SETTLE) begin
      $display("FAIL settle_hold: got %b want %b", outs, O_SETTLE); failures++;
    end
    repeat (2) step();
    checks++;
    if (outs !== O_IDLE) begin
      $display("FAIL settle_timeout: got %b want %b", outs, O_IDLE); failures++;
    end
  endtask

  task automatic test_rotation();
    logic [1:0] disp;
    logic [7:0] exp;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 42; k++) begin
      disp = (k >= 20 && k < 40) ? 2'd1 : 2'd0;
      exp  = {(k == 0), 1'b1, 1'b0, 1'b0, disp, 1'b0, 1'b0};
      checks++;
      if (outs !== exp) begin
        $display("FAIL rotation k=%0d: got %b want %b", k, outs, exp); failures++;
      end
      if (k % 5 == 4) drive(1'b0, 1'b0, 1'b0, 1'b1);
      else            step();
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (outs !== O_WAIT) begin
      $display("FAIL b2b_wait: got %b want %b", outs, O_WAIT); failures++;
    end
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    checks++;
    if (outs !== O_IDLE) begin
      $display("FAIL midtrip_reset: got %b want %b", outs, O_IDLE); failures++;
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (outs !== O_DRIVE_CLR) begin
      $display("FAIL restart_clr: got %b want %b", outs, O_DRIVE_CLR); failures++;
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (outs !== O_SETTLE) begin
      $display("FAIL stop_over_wait: got %b want %b", outs, O_SETTLE); failures++;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_DRIVE_CLR) begin
      $display("FAIL settle_new_trip: got %b want %b", outs, O_DRIVE_CLR); failures++;
    end
    step();
    checks++;
    if (outs !== O_DRIVE) begin
      $display("FAIL new_trip_clr_drop: got %b want %b", outs, O_DRIVE); failures++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_auto_wait();
    test_manual_wait();
    test_stop_settle();
    test_rotation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
